// File: rtl/cpu_token_queue.sv
// Packed FIFO of buffer-ownership tokens handed from the snooper to the CPU.
// Entry 0 is always the head. Token 0 means "no buffer" and is never stored.
module cpu_token_queue #(
  parameter int N_BUFS = 3,
  parameter int TOK_W  = $clog2(N_BUFS + 1),
  parameter int DEPTH  = N_BUFS,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TOK_W-1:0] enq_tok,
  input  logic             enq_en,
  input  logic             deq,
  input  logic             flush,
  input  logic             err_clr,
  output logic [TOK_W-1:0] head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             deq_empty,
  output logic             dup_err
);

  logic [TOK_W-1:0] entries_q [DEPTH];
  logic [TOK_W-1:0] entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             deq_empty_q, deq_empty_d;
  logic             dup_err_q, dup_err_d;

  logic enq_req;
  logic deq_ok;
  logic is_full;
  logic dup_hit;

  assign enq_req = enq_en && (enq_tok != '0);
  assign is_full = (count_q == CNT_W'(DEPTH));
  assign deq_ok  = deq && (count_q != '0);

  // The head being dequeued this cycle is leaving, so it cannot be a duplicate.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(deq_ok && i == 0) && (CNT_W'(i) < count_q) && (entries_q[i] == enq_tok))
        dup_hit = 1'b1;
    end
  end

  always_comb begin
    entries_d   = entries_q;
    count_d     = count_q;
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    deq_empty_d = err_clr ? 1'b0 : deq_empty_q;
    dup_err_d   = err_clr ? 1'b0 : dup_err_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
      count_d = '0;
    end else begin
      if (deq_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i + 1];
        entries_d[DEPTH - 1] = '0;
      end
      if (deq && !deq_ok) deq_empty_d = 1'b1;

      if (enq_req) begin
        if (dup_hit) dup_err_d = 1'b1;
        if (deq_ok) begin
          // Shift-and-fill: the new token takes the slot vacated at the top.
          for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) == count_q - CNT_W'(1)) entries_d[i] = enq_tok;
        end else if (!is_full) begin
          for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) == count_q) entries_d[i] = enq_tok;
          count_d = count_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (deq_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      deq_empty_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      deq_empty_q <= deq_empty_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign head       = entries_q[0];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
  assign full       = is_full;
  assign empty      = (count_q == '0);
  assign overflow   = overflow_q;
  assign deq_empty  = deq_empty_q;
  assign dup_err    = dup_err_q;

endmodule

// File: tb/tb_cpu_token_queue.sv
// Directed bench for cpu_token_queue: a default instance (3 buffers, depth 3)
// and a wider instance (7 buffers, depth 4) driven by hand-computed vectors.
module tb_cpu_token_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Default instance: TOK_W=2, CNT_W=2
  logic       a_rst, a_enq_en, a_deq, a_flush, a_err_clr;
  logic [1:0] a_enq_tok, a_head, a_count;
  logic       a_head_valid, a_full, a_empty, a_overflow, a_deq_empty, a_dup_err;

  // Wide instance: TOK_W=3, CNT_W=3
  logic       b_rst, b_enq_en, b_deq, b_flush, b_err_clr;
  logic [2:0] b_enq_tok, b_head, b_count;
  logic       b_head_valid, b_full, b_empty, b_overflow, b_deq_empty, b_dup_err;

  cpu_token_queue dut_a (
    .clk(clk), .rst(a_rst), .enq_tok(a_enq_tok), .enq_en(a_enq_en), .deq(a_deq),
    .flush(a_flush), .err_clr(a_err_clr), .head(a_head), .head_valid(a_head_valid),
    .count(a_count), .full(a_full), .empty(a_empty), .overflow(a_overflow),
    .deq_empty(a_deq_empty), .dup_err(a_dup_err)
  );

  cpu_token_queue #(.N_BUFS(7), .DEPTH(4)) dut_b (
    .clk(clk), .rst(b_rst), .enq_tok(b_enq_tok), .enq_en(b_enq_en), .deq(b_deq),
    .flush(b_flush), .err_clr(b_err_clr), .head(b_head), .head_valid(b_head_valid),
    .count(b_count), .full(b_full), .empty(b_empty), .overflow(b_overflow),
    .deq_empty(b_deq_empty), .dup_err(b_dup_err)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock of stimulus on instance sel (0=default, 1=wide); inputs return to idle after the edge.
  task automatic applyStimulus(input bit sel, input bit rst, input bit en, input int tok,
                               input bit dq, input bit fl, input bit ec);
    if (sel == 1'b0) begin
      a_rst = rst; a_enq_en = en; a_enq_tok = tok[1:0]; a_deq = dq; a_flush = fl; a_err_clr = ec;
    end else begin
      b_rst = rst; b_enq_en = en; b_enq_tok = tok[2:0]; b_deq = dq; b_flush = fl; b_err_clr = ec;
    end
    @(posedge clk);
    #1;
    a_rst = 0; a_enq_en = 0; a_enq_tok = '0; a_deq = 0; a_flush = 0; a_err_clr = 0;
    b_rst = 0; b_enq_en = 0; b_enq_tok = '0; b_deq = 0; b_flush = 0; b_err_clr = 0;
  endtask

  task automatic checkA(input string tag, input int hd, input int hv, input int cnt,
                        input int fu, input int em, input int ov, input int de, input int du);
    checkOutput({tag, ".head"}, a_head, hd);
    checkOutput({tag, ".head_valid"}, a_head_valid, hv);
    checkOutput({tag, ".count"}, a_count, cnt);
    checkOutput({tag, ".full"}, a_full, fu);
    checkOutput({tag, ".empty"}, a_empty, em);
    checkOutput({tag, ".overflow"}, a_overflow, ov);
    checkOutput({tag, ".deq_empty"}, a_deq_empty, de);
    checkOutput({tag, ".dup_err"}, a_dup_err, du);
  endtask

  task automatic checkB(input string tag, input int hd, input int hv, input int cnt,
                        input int fu, input int em, input int ov, input int de, input int du);
    checkOutput({tag, ".head"}, b_head, hd);
    checkOutput({tag, ".head_valid"}, b_head_valid, hv);
    checkOutput({tag, ".count"}, b_count, cnt);
    checkOutput({tag, ".full"}, b_full, fu);
    checkOutput({tag, ".empty"}, b_empty, em);
    checkOutput({tag, ".overflow"}, b_overflow, ov);
    checkOutput({tag, ".deq_empty"}, b_deq_empty, de);
    checkOutput({tag, ".dup_err"}, b_dup_err, du);
  endtask

  initial begin
    a_rst = 1; a_enq_en = 0; a_enq_tok = '0; a_deq = 0; a_flush = 0; a_err_clr = 0;
    b_rst = 1; b_enq_en = 0; b_enq_tok = '0; b_deq = 0; b_flush = 0; b_err_clr = 0;
    #1;

    // ---------------- default instance ----------------
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 1, 0, 0);          // reset wins over enq/deq
    checkA("a_reset", 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkA("a_idle", 0, 0, 0, 0, 1, 0, 0, 0);

    applyStimulus(0, 0, 1, 2, 0, 0, 0);
    checkA("a_enq2", 2, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkA("a_enq1", 2, 1, 2, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 0, 0, 0);
    checkA("a_enq3", 2, 1, 3, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_deq1", 1, 1, 2, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_deq2", 3, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_deq3", 0, 0, 0, 0, 1, 0, 0, 0);

    // Overflow with a duplicate token, then clear
    applyStimulus(0, 0, 1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkA("a_ovf", 2, 1, 3, 1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkA("a_errclr", 2, 1, 3, 1, 0, 0, 0, 0);

    // Full + enq + deq: the dequeued 2 is not a duplicate
    applyStimulus(0, 0, 1, 2, 1, 0, 0);
    checkA("a_fullswap", 1, 1, 3, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_drain1", 3, 1, 2, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_drain2", 2, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkA("a_drain3", 0, 0, 0, 0, 1, 0, 0, 0);

    // Deq on empty with a simultaneous enqueue
    applyStimulus(0, 0, 1, 3, 1, 0, 0);
    checkA("a_deqempty_enq", 3, 1, 1, 0, 0, 0, 1, 0);
    // Flush beats enq and deq, flags stay
    applyStimulus(0, 0, 1, 1, 1, 1, 0);
    checkA("a_flush", 0, 0, 0, 0, 1, 0, 1, 0);
    // Flush on empty with deq must not raise a new deq_empty; clear first to see it
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkA("a_clr2", 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkA("a_flush_deq", 0, 0, 0, 0, 1, 0, 0, 0);
    // Set wins over err_clr
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkA("a_setwins", 0, 0, 0, 0, 1, 0, 1, 0);

    // ---------------- wide instance ----------------
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkB("b_reset", 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 5, 0, 0, 0);
    checkB("b_enq5", 5, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 6, 0, 0, 0);
    applyStimulus(1, 0, 1, 7, 0, 0, 0);
    applyStimulus(1, 0, 1, 4, 0, 0, 0);
    checkB("b_full", 5, 1, 4, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    checkB("b_ovf", 5, 1, 4, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkB("b_nulltok", 5, 1, 4, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkB("b_deq", 6, 1, 3, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 3, 1, 0, 0);
    checkB("b_midrst", 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 2, 0, 0, 0);
    checkB("b_after_rst", 2, 1, 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_token_queue.md
Name: cpu_token_queue

Overview:
- Parametrised successor to the fixed 3-entry, 2-bit CPU token queue used by the packet-buffer controller.
- Holds buffer-ownership tokens handed over from the snooper until the CPU side dequeues them, in strict FIFO order.
- Generalises buffer count and queue depth, and adds occupancy count, full/empty flags, flush, and sticky error flags for overflow, empty-dequeue and duplicate tokens.
- Token value 0 is the null token ("no buffer") and is never stored.

Parameters:
N_BUFS, 3, number of packet buffers; legal tokens are 1..N_BUFS
TOK_W, $clog2(N_BUFS+1), token width in bits (2 for the default)
DEPTH, N_BUFS, queue entries; must be >= 1
CNT_W, $clog2(DEPTH+1), width of the count output

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
enq_tok  in  TOK_W  token offered by the snooper
enq_en  in  1  qualifies enq_tok; an enqueue is requested when enq_en=1 and enq_tok!=0
deq  in  1  CPU consumes the current head
flush  in  1  synchronous clear of all entries
err_clr  in  1  clears all sticky error flags
head  out  TOK_W  oldest token; 0 when empty
head_valid  out  1  head is a real token
count  out  CNT_W  number of stored tokens
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky: an enqueue was dropped because the queue was full
deq_empty  out  1  sticky: deq was asserted while the queue was empty
dup_err  out  1  sticky: an enqueued token equals a token already stored

Behaviour:
- Reset (rst=1 at an edge): all entries=0, count=0, empty=1, full=0, head=0, head_valid=0, all sticky flags=0. Reset wins over every other input. Reset mid-operation discards stored tokens.
- Storage: DEPTH registers kept packed, entry 0 is the head.
- head = entry0, driven combinationally from registers only; no input-to-output combinational path.
- head_valid = (count!=0); full, empty and count are likewise decoded from registered state.
- Enqueue request (enq_en=1, enq_tok!=0):
  - Not full, no deq: token written at index count; count+1.
  - deq together with a non-empty queue: entries shift down by one and the token lands at index count-1; count is unchanged. This holds when full, so full+enq+deq is accepted.
  - Full with no deq: token dropped, state unchanged, overflow<=1.
- enq_en=1 with enq_tok=0: no-op, no flag.
- Dequeue on a non-empty queue, no enqueue: entries shift down; the vacated top entry becomes 0; count-1.
- deq while empty: no state change; deq_empty<=1. If an enqueue is also requested, it is accepted, and the token appears on head the next cycle.
- Latency: a token enqueued into an empty queue at edge t is on head immediately after edge t (one-cycle latency). head updates on the edge where deq is sampled.
- Duplicate check: an accepted or dropped enqueue whose token equals any stored entry sets dup_err<=1. The entry being dequeued in the same cycle is excluded from the compare. The token is still enqueued if there is space; the flag is diagnostic only.
- flush=1: all entries<=0, count<=0. Takes priority over enq and deq in the same cycle; neither is performed and neither sets a flag.
- Sticky flags:
  - Set on the edge after the event and held until rst or err_clr.
  - err_clr and a new set event in the same cycle: set wins.
  - flush does not clear the flags.
- Token values > N_BUFS are stored as-is; no range check.
- count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Reset, then idle: head=0, head_valid=0, count=0, empty=1, full=0, all flags 0.
- Defaults: enq 2, 1, 3 on consecutive cycles (no deq) -> count 1,2,3, full=1 after the third, head=2 throughout. Then deq x3 -> head 1, 3, 0, count 2,1,0, empty=1.
- Full (2,1,3), enq 1 without deq -> dropped, overflow=1, dup_err=1, contents unchanged. Then err_clr -> both flags 0.
- Full (2,1,3), enq 2 with deq in the same cycle -> head=1, contents 1,3,2, count=3, dup_err=0 (the dequeued 2 is excluded), overflow=0.
- Empty queue, deq together with enq 3 -> deq_empty=1, next cycle head=3, count=1. Then flush with enq 1 and deq asserted -> count=0, head=0, deq_empty still 1.
- N_BUFS=7, DEPTH=4 (TOK_W=3): enq 5,6,7,4, then enq 1 -> overflow=1. Then enq_en=1 with enq_tok=0 -> no change. Mid-sequence rst -> all outputs at reset values.
